lfsr_gen: RTL

Parametrised Fibonacci LFSR, successor to the fixed 3-bit generator. Adds generic width and tap polynomial, runtime seed load, step enable, cycle-period measurement with a wrap pulse, and all-zero lockup detection. It sits beside test-pattern and scrambler logic as a free-running or gated pseudo-random source.

---
 rtl/lfsr_gen.sv | 60 ++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load, wrap pulse, period measurement and lockup detect.
// Define LFSR_LOCKUP_RECOVER_EN to reseed automatically when stepping from the all-zero state.
module lfsr_gen #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             set,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH:1]   Q,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);
  logic [WIDTH-1:0] seed_reg, cnt, nxt;
  logic fb, recover;
  assign fb = ^(Q & TAPS);
  assign nxt = {Q[WIDTH-1:1], fb};
  assign bit_out = Q[WIDTH];
  assign lockup = ~|Q;
`ifdef LFSR_LOCKUP_RECOVER_EN
  assign recover = en & lockup;
`else
  assign recover = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (set) begin
      Q <= SEED;
      seed_reg <= SEED;
      cnt <= '0;
      period <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      Q <= load_val;
      seed_reg <= load_val;
      cnt <= '0;
      wrap <= 1'b0;
    end else if (recover) begin
      Q <= SEED;
      seed_reg <= SEED;
      cnt <= '0;
      wrap <= 1'b0;
    end else if (en && nxt == seed_reg) begin
      Q <= nxt;
      wrap <= 1'b1;
      period <= cnt + 1'b1;
      cnt <= '0;
    end else if (en) begin
      Q <= nxt;
      cnt <= cnt + 1'b1;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule
